atm_session_ctrl: RTL and testbench
===================================

Name: atm_session_ctrl

Overview:
- Session/transaction controller sequencing the ATM balance datapath.
- Tracks card insertion, language select, PIN entry with lockout, and inactivity timeout.
- Validates withdraw/deposit/balance requests against the current balance (CB); issues one request at a time to the balance datapath over a req/ack handshake.
- Sits between the front-panel inputs and the balance register/datapath. Owns session sequencing only; never stores the balance.

Parameters:
- PIN_VALUE, 4'b1101, PIN accepted for the session.
- MAX_TRIES, 3, wrong-PIN attempts before card retention (1..7).
- TIMEOUT_CYCLES, 64, idle cycles in an interactive state before forced eject (>=2).
- BAL_W, 8, balance width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- IC  in  1  card present level.
- LC  in  1  language chosen level.
- Pin  in  4  entered PIN, sampled when pin_valid=1.
- pin_valid  in  1  one-cycle PIN-entry strobe.
- Operation  in  2  00 withdraw, 01 deposit, 10 balance, 11 exit; sampled when op_valid=1.
- op_valid  in  1  one-cycle operation strobe.
- WithDraw_Amount  in  6  withdraw amount.
- Deposit_Amount  in  5  deposit amount.
- goMain  in  1  abandon withdraw retry, return to menu.
- CB  in  BAL_W  current balance from the datapath.
- dp_req  out  1  datapath request.
- dp_op  out  2  datapath operation (00 sub, 01 add, 10 read).
- dp_amount  out  BAL_W  zero-extended operand.
- dp_ack  in  1  datapath completion, one cycle.
- shown_balance  out  BAL_W  balance latched on completion.
- op_done  out  1  one-cycle pulse on successful operation.
- op_err  out  1  one-cycle pulse on a rejected operation.
- card_eject  out  1  one-cycle pulse on eject.
- card_retained  out  1  high while locked.
- tries_left  out  3  remaining PIN attempts.
- session_active  out  1  high in MENU, EXEC, WD_RETRY.

Behaviour:
- Reset: state IDLE, dp_req=0, dp_op=0, dp_amount=0, shown_balance=0, op_done=0, op_err=0, card_eject=0, card_retained=0, tries_left=MAX_TRIES, session_active=0, timeout counter=0. Reset wins over every other input, including mid-handshake.
- States: IDLE, LANG, PIN, MENU, EXEC, WD_RETRY, EJECT, LOCKED.
- IDLE:
  - IC=1 -> LANG.
  - tries_left reloads to MAX_TRIES on entry.
- LANG:
  - LC=1 -> PIN.
  - IC=0 -> IDLE, with no eject pulse.
- PIN (on pin_valid):
  - Pin==PIN_VALUE -> MENU; tries_left=MAX_TRIES.
  - Otherwise tries_left-1. If the result is 0 -> LOCKED; else stay in PIN.
- MENU (on op_valid):
  - 00: WithDraw_Amount > CB -> op_err pulse, go to WD_RETRY. Otherwise -> EXEC with dp_op=00, dp_amount={0,WithDraw_Amount}.
  - 01: CB + Deposit_Amount computed at BAL_W+1 bits. Result > 2^BAL_W-1 -> op_err pulse, stay in MENU. Otherwise -> EXEC with dp_op=01.
  - 10 -> EXEC with dp_op=10, dp_amount=0.
  - 11 -> EJECT.
- WD_RETRY:
  - op_valid with Operation=00 re-checks as in MENU (fail: op_err, stay; pass: EXEC).
  - goMain=1 -> MENU; goMain has priority over a same-cycle op_valid.
  - Other op_valid is ignored.
- EXEC:
  - dp_req=1 from the cycle after entry. dp_op and dp_amount are held stable until dp_ack.
  - On dp_ack: dp_req=0 next cycle, shown_balance<=CB sampled in the ack cycle, op_done pulse, go to MENU.
  - Request latency is at least 1 cycle; no second request while dp_req=1.
- Card removal:
  - IC=0 in PIN, MENU or WD_RETRY -> EJECT.
  - IC=0 in EXEC is deferred until dp_ack; the handshake always completes, then EJECT (op_done still pulses).
- EJECT: card_eject=1 for one cycle, then IDLE.
- LOCKED: card_retained=1; stays until IC=0, then IDLE. No eject pulse.
- Timeout:
  - Counter runs in LANG, PIN, MENU, WD_RETRY.
  - Clears on any pin_valid, op_valid or goMain, and on state change.
  - At TIMEOUT_CYCLES -> EJECT (LANG included).
  - Counter frozen and cleared in EXEC, IDLE, EJECT, LOCKED.
- Strobes arriving in states that do not consume them are ignored.

Test Plan:
- rst; IC=1, LC=1, pin_valid with Pin=1101, CB=50; op 00 with WithDraw_Amount=20, dp_ack 3 cycles later with CB=30 -> dp_req held 3 cycles, dp_op=00, dp_amount=20, shown_balance=30, one op_done.
- Session at PIN; three pin_valid with Pin=0000 -> tries_left 2,1,0; LOCKED, card_retained=1; IC=0 -> IDLE, no card_eject.
- MENU with CB=10; withdraw 40 -> op_err, WD_RETRY; retry 5 -> EXEC. Repeat, then goMain=1 with same-cycle op_valid -> MENU, no dp_req.
- CB=250; deposit 10 -> op_err, stays MENU, no dp_req. Deposit 5 -> dp_op=01, dp_amount=5, op_done.
- MENU idle for 64 cycles -> card_eject pulse, IDLE. IC=0 during EXEC -> waits for dp_ack, op_done, then card_eject.
- rst asserted while dp_req=1 -> next cycle all outputs at reset values, state IDLE, tries_left=3.

Source files
------------

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: ATM session sequencer. It handles card, language, PIN lockout,
// menu validation, the datapath req/ack handshake and the inactivity timeout.
module atm_session_ctrl #(
  parameter logic [3:0]  PIN_VALUE      = 4'b1101,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned BAL_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IC,
  input  logic             LC,
  input  logic [3:0]       Pin,
  input  logic             pin_valid,
  input  logic [1:0]       Operation,
  input  logic             op_valid,
  input  logic [5:0]       WithDraw_Amount,
  input  logic [4:0]       Deposit_Amount,
  input  logic             goMain,
  input  logic [BAL_W-1:0] CB,
  output logic             dp_req,
  output logic [1:0]       dp_op,
  output logic [BAL_W-1:0] dp_amount,
  input  logic             dp_ack,
  output logic [BAL_W-1:0] shown_balance,
  output logic             op_done,
  output logic             op_err,
  output logic             card_eject,
  output logic             card_retained,
  output logic [2:0]       tries_left,
  output logic             session_active
);

  localparam int unsigned         TMR_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned         SUM_W      = BAL_W + 1;
  localparam logic [2:0]          TRIES_INIT = 3'(MAX_TRIES);
  localparam logic [TMR_W-1:0]    TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LANG, S_PIN, S_MENU, S_EXEC, S_WD_RETRY, S_EJECT, S_LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               pending_q, pending_d;
  logic               dp_req_q, dp_req_d;
  logic [1:0]         dp_op_q, dp_op_d;
  logic [BAL_W-1:0]   dp_amount_q, dp_amount_d;
  logic [BAL_W-1:0]   shown_balance_q, shown_balance_d;
  logic               op_done_q, op_done_d;
  logic               op_err_q, op_err_d;
  logic               card_eject_q, card_eject_d;
  logic               card_retained_q, card_retained_d;
  logic [2:0]         tries_left_q, tries_left_d;
  logic               session_active_q, session_active_d;

  logic [BAL_W-1:0]   wd_ext;
  logic [BAL_W-1:0]   dep_ext;
  logic [SUM_W-1:0]   dep_sum;
  logic               wd_ok;
  logic               activity;
  logic               interactive;

  assign wd_ext      = BAL_W'(WithDraw_Amount);
  assign dep_ext     = BAL_W'(Deposit_Amount);
  assign dep_sum     = {1'b0, CB} + SUM_W'(Deposit_Amount);
  assign wd_ok       = (wd_ext <= CB);
  assign activity    = pin_valid | op_valid | goMain;
  assign interactive = (state_q == S_LANG) || (state_q == S_PIN) ||
                       (state_q == S_MENU) || (state_q == S_WD_RETRY);

  // Next-state, timeout and registered-output computation
  always_comb begin
    state_d         = state_q;
    timer_d         = '0;
    pending_d       = pending_q;
    dp_op_d         = dp_op_q;
    dp_amount_d     = dp_amount_q;
    shown_balance_d = shown_balance_q;
    tries_left_d    = tries_left_q;
    op_done_d       = 1'b0;
    op_err_d        = 1'b0;

    case (state_q)
      S_IDLE: if (IC) state_d = S_LANG;
      S_LANG: begin
        if (!IC)     state_d = S_IDLE;
        else if (LC) state_d = S_PIN;
      end
      S_PIN: begin
        if (!IC) begin
          state_d = S_EJECT;
        end else if (pin_valid) begin
          if (Pin == PIN_VALUE) begin
            state_d      = S_MENU;
            tries_left_d = TRIES_INIT;
          end else begin
            tries_left_d = tries_left_q - 3'd1;
            if (tries_left_q == 3'd1) state_d = S_LOCKED;
          end
        end
      end
      S_MENU: begin
        if (!IC) begin
          state_d = S_EJECT;
        end else if (op_valid) begin
          case (Operation)
            2'b00: begin
              if (!wd_ok) begin
                op_err_d = 1'b1;
                state_d  = S_WD_RETRY;
              end else begin
                state_d     = S_EXEC;
                dp_op_d     = 2'b00;
                dp_amount_d = wd_ext;
              end
            end
            2'b01: begin
              if (dep_sum[BAL_W]) begin
                op_err_d = 1'b1;
              end else begin
                state_d     = S_EXEC;
                dp_op_d     = 2'b01;
                dp_amount_d = dep_ext;
              end
            end
            2'b10: begin
              state_d     = S_EXEC;
              dp_op_d     = 2'b10;
              dp_amount_d = '0;
            end
            default: state_d = S_EJECT;
          endcase
        end
      end
      S_WD_RETRY: begin
        if (!IC) begin
          state_d = S_EJECT;
        end else if (goMain) begin
          state_d = S_MENU;
        end else if (op_valid && (Operation == 2'b00)) begin
          if (!wd_ok) begin
            op_err_d = 1'b1;
          end else begin
            state_d     = S_EXEC;
            dp_op_d     = 2'b00;
            dp_amount_d = wd_ext;
          end
        end
      end
      S_EXEC: begin
        // Card removal mid-handshake is remembered and honoured after the ack
        if (!IC) pending_d = 1'b1;
        if (dp_ack) begin
          shown_balance_d = CB;
          op_done_d       = 1'b1;
          pending_d       = 1'b0;
          state_d         = (pending_q || !IC) ? S_EJECT : S_MENU;
        end
      end
      S_EJECT:  state_d = S_IDLE;
      S_LOCKED: if (!IC) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Idle counting only while waiting for the user in an interactive state
    if (interactive && (state_d == state_q) && !activity) begin
      if (timer_q == TMR_LAST) state_d = S_EJECT;
      else                     timer_d = timer_q + TMR_W'(1);
    end

    if (state_d == S_IDLE) tries_left_d = TRIES_INIT;

    dp_req_d         = (state_d == S_EXEC);
    card_eject_d     = (state_d == S_EJECT);
    card_retained_d  = (state_d == S_LOCKED);
    session_active_d = (state_d == S_MENU) || (state_d == S_EXEC) ||
                       (state_d == S_WD_RETRY);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      timer_q          <= '0;
      pending_q        <= 1'b0;
      dp_req_q         <= 1'b0;
      dp_op_q          <= 2'b00;
      dp_amount_q      <= '0;
      shown_balance_q  <= '0;
      op_done_q        <= 1'b0;
      op_err_q         <= 1'b0;
      card_eject_q     <= 1'b0;
      card_retained_q  <= 1'b0;
      tries_left_q     <= TRIES_INIT;
      session_active_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      pending_q        <= pending_d;
      dp_req_q         <= dp_req_d;
      dp_op_q          <= dp_op_d;
      dp_amount_q      <= dp_amount_d;
      shown_balance_q  <= shown_balance_d;
      op_done_q        <= op_done_d;
      op_err_q         <= op_err_d;
      card_eject_q     <= card_eject_d;
      card_retained_q  <= card_retained_d;
      tries_left_q     <= tries_left_d;
      session_active_q <= session_active_d;
    end
  end

  assign dp_req         = dp_req_q;
  assign dp_op          = dp_op_q;
  assign dp_amount      = dp_amount_q;
  assign shown_balance  = shown_balance_q;
  assign op_done        = op_done_q;
  assign op_err         = op_err_q;
  assign card_eject     = card_eject_q;
  assign card_retained  = card_retained_q;
  assign tries_left     = tries_left_q;
  assign session_active = session_active_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: table vectors, directed corner sequences and random
// stimulus, all compared against a session-level reference model.
module tb_atm_session_ctrl;

  localparam int unsigned BAL_W     = 8;
  localparam int          MAX_TRIES = 3;
  localparam int          TIMEOUT   = 64;
  localparam int          PIN_OK    = 13;

  typedef struct packed {
    logic       rst;
    logic       ic;
    logic       lc;
    logic [3:0] pin;
    logic       pv;
    logic [1:0] op;
    logic       ov;
    logic [5:0] wd;
    logic [4:0] dep;
    logic       gm;
    logic [7:0] cb;
    logic       ack;
  } in_t;

  typedef struct packed {
    logic       req;
    logic [1:0] op;
    logic [7:0] amt;
    logic [7:0] shown;
    logic       done;
    logic       err;
    logic       ej;
    logic       ret;
    logic [2:0] tries;
    logic       active;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t cur;
  logic             dp_req, op_done, op_err, card_eject, card_retained, session_active;
  logic [1:0]       dp_op;
  logic [BAL_W-1:0] dp_amount, shown_balance;
  logic [2:0]       tries_left;

  atm_session_ctrl dut (
    .clk(clk), .rst(cur.rst), .IC(cur.ic), .LC(cur.lc), .Pin(cur.pin),
    .pin_valid(cur.pv), .Operation(cur.op), .op_valid(cur.ov),
    .WithDraw_Amount(cur.wd), .Deposit_Amount(cur.dep), .goMain(cur.gm),
    .CB(cur.cb), .dp_req(dp_req), .dp_op(dp_op), .dp_amount(dp_amount),
    .dp_ack(cur.ack), .shown_balance(shown_balance), .op_done(op_done),
    .op_err(op_err), .card_eject(card_eject), .card_retained(card_retained),
    .tries_left(tries_left), .session_active(session_active)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [7:0] cb_level = 8'd50;

  // Reference model: session phase as a name plus plain integer bookkeeping
  string m_ph = "IDLE";
  int    m_tries = MAX_TRIES, m_idle = 0, m_op = 0, m_amt = 0, m_shown = 0;
  bit    m_pend = 0, m_done = 0, m_err = 0;

  task automatic model_step();
    string nx;
    bit act, inter;
    int cb;
    m_done = 0;
    m_err  = 0;
    if (cur.rst) begin
      m_ph = "IDLE"; m_tries = MAX_TRIES; m_idle = 0; m_pend = 0;
      m_op = 0; m_amt = 0; m_shown = 0;
      return;
    end
    nx    = m_ph;
    cb    = int'(cur.cb);
    act   = cur.pv || cur.ov || cur.gm;
    inter = (m_ph == "LANG") || (m_ph == "PIN") || (m_ph == "MENU") || (m_ph == "WD_RETRY");
    if (m_ph == "IDLE") begin
      if (cur.ic) nx = "LANG";
    end else if (m_ph == "LANG") begin
      if (!cur.ic) nx = "IDLE";
      else if (cur.lc) nx = "PIN";
    end else if (m_ph == "PIN") begin
      if (!cur.ic) nx = "EJECT";
      else if (cur.pv) begin
        if (int'(cur.pin) == PIN_OK) begin
          nx = "MENU"; m_tries = MAX_TRIES;
        end else begin
          m_tries = m_tries - 1;
          if (m_tries == 0) nx = "LOCKED";
        end
      end
    end else if (m_ph == "MENU" || m_ph == "WD_RETRY") begin
      if (!cur.ic) nx = "EJECT";
      else if (m_ph == "WD_RETRY" && cur.gm) nx = "MENU";
      else if (cur.ov) begin
        if (cur.op == 2'd0) begin
          if (int'(cur.wd) > cb) begin
            m_err = 1; nx = "WD_RETRY";
          end else begin
            nx = "EXEC"; m_op = 0; m_amt = int'(cur.wd);
          end
        end else if (m_ph == "MENU") begin
          if (cur.op == 2'd1) begin
            if (cb + int'(cur.dep) > (1 << BAL_W) - 1) m_err = 1;
            else begin nx = "EXEC"; m_op = 1; m_amt = int'(cur.dep); end
          end else if (cur.op == 2'd2) begin
            nx = "EXEC"; m_op = 2; m_amt = 0;
          end else nx = "EJECT";
        end
      end
    end else if (m_ph == "EXEC") begin
      if (!cur.ic) m_pend = 1;
      if (cur.ack) begin
        m_shown = cb; m_done = 1;
        nx = m_pend ? "EJECT" : "MENU";
        m_pend = 0;
      end
    end else if (m_ph == "EJECT") begin
      nx = "IDLE";
    end else if (m_ph == "LOCKED") begin
      if (!cur.ic) nx = "IDLE";
    end
    if (inter && nx == m_ph && !act) begin
      m_idle = m_idle + 1;
      if (m_idle >= TIMEOUT) nx = "EJECT";
    end
    if (nx != m_ph || !inter || act) m_idle = 0;
    if (nx == "IDLE") m_tries = MAX_TRIES;
    m_ph = nx;
  endtask

  function automatic out_t model_out();
    out_t o;
    o.req    = (m_ph == "EXEC");
    o.op     = 2'(m_op);
    o.amt    = 8'(m_amt);
    o.shown  = 8'(m_shown);
    o.done   = m_done;
    o.err    = m_err;
    o.ej     = (m_ph == "EJECT");
    o.ret    = (m_ph == "LOCKED");
    o.tries  = 3'(m_tries);
    o.active = (m_ph == "MENU") || (m_ph == "EXEC") || (m_ph == "WD_RETRY");
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.req = dp_req; o.op = dp_op; o.amt = dp_amount; o.shown = shown_balance;
    o.done = op_done; o.err = op_err; o.ej = card_eject; o.ret = card_retained;
    o.tries = tries_left; o.active = session_active;
    return o;
  endfunction

  function automatic in_t mk_in(bit rst, bit ic, bit lc, int pin, bit pv, int op, bit ov,
                                int wd, int dep, bit gm, int cb, bit ack);
    in_t i;
    i.rst = rst; i.ic = ic; i.lc = lc; i.pin = 4'(pin); i.pv = pv; i.op = 2'(op);
    i.ov = ov; i.wd = 6'(wd); i.dep = 5'(dep); i.gm = gm; i.cb = 8'(cb); i.ack = ack;
    return i;
  endfunction

  function automatic out_t mk_out(bit req, int op, int amt, int shown, bit done, bit err,
                                  bit ej, bit ret, int tries, bit active);
    out_t o;
    o.req = req; o.op = 2'(op); o.amt = 8'(amt); o.shown = 8'(shown); o.done = done;
    o.err = err; o.ej = ej; o.ret = ret; o.tries = 3'(tries); o.active = active;
    return o;
  endfunction

  function automatic in_t idle_in();
    return mk_in(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, int'(cb_level), 0);
  endfunction

  task automatic chk_vec(string name, out_t got, out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // One clock: model advances on the edge, DUT compared on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk_vec("model", dut_out(), model_out());
  endtask

  task automatic run(in_t i);
    cur = i;
    cycle();
    cur = idle_in();
  endtask

  task automatic open_session(int cb);
    cb_level = 8'(cb);
    run(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, cb, 0));
    run(idle_in());
    run(idle_in());
    run(mk_in(0, 1, 1, PIN_OK, 1, 0, 0, 0, 0, 0, cb, 0));
  endtask

  vec_t tbl[$];

  initial begin
    out_t rs;
    cur = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 50, 0);
    rs  = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);

    // Withdraw with 3-cycle ack, then exit, then PIN lockout
    tbl.push_back('{mk_in(1,0,0,0,0,0,0,0,0,0,50,0),   rs});
    tbl.push_back('{mk_in(0,1,0,0,0,0,0,0,0,0,50,0),   rs});
    tbl.push_back('{mk_in(0,1,1,0,0,0,0,0,0,0,50,0),   rs});
    tbl.push_back('{mk_in(0,1,1,13,1,0,0,0,0,0,50,0),  mk_out(0,0,0,0,0,0,0,0,3,1)});
    tbl.push_back('{mk_in(0,1,1,0,0,0,1,20,0,0,50,0),  mk_out(1,0,20,0,0,0,0,0,3,1)});
    tbl.push_back('{mk_in(0,1,1,0,0,0,0,0,0,0,50,0),   mk_out(1,0,20,0,0,0,0,0,3,1)});
    tbl.push_back('{mk_in(0,1,1,0,0,0,0,0,0,0,50,0),   mk_out(1,0,20,0,0,0,0,0,3,1)});
    tbl.push_back('{mk_in(0,1,1,0,0,0,0,0,0,0,30,1),   mk_out(0,0,20,30,1,0,0,0,3,1)});
    tbl.push_back('{mk_in(0,1,1,0,0,0,0,0,0,0,30,0),   mk_out(0,0,20,30,0,0,0,0,3,1)});
    tbl.push_back('{mk_in(0,1,1,0,0,3,1,0,0,0,30,0),   mk_out(0,0,20,30,0,0,1,0,3,0)});
    tbl.push_back('{mk_in(0,0,1,0,0,0,0,0,0,0,30,0),   mk_out(0,0,20,30,0,0,0,0,3,0)});
    tbl.push_back('{mk_in(0,1,1,0,0,0,0,0,0,0,30,0),   mk_out(0,0,20,30,0,0,0,0,3,0)});
    tbl.push_back('{mk_in(0,1,1,0,0,0,0,0,0,0,30,0),   mk_out(0,0,20,30,0,0,0,0,3,0)});
    tbl.push_back('{mk_in(0,1,1,0,1,0,0,0,0,0,30,0),   mk_out(0,0,20,30,0,0,0,0,2,0)});
    tbl.push_back('{mk_in(0,1,1,0,1,0,0,0,0,0,30,0),   mk_out(0,0,20,30,0,0,0,0,1,0)});
    tbl.push_back('{mk_in(0,1,1,0,1,0,0,0,0,0,30,0),   mk_out(0,0,20,30,0,0,0,1,0,0)});
    tbl.push_back('{mk_in(0,1,1,0,0,0,0,0,0,0,30,0),   mk_out(0,0,20,30,0,0,0,1,0,0)});
    tbl.push_back('{mk_in(0,0,1,0,0,0,0,0,0,0,30,0),   mk_out(0,0,20,30,0,0,0,0,3,0)});

    for (int k = 0; k < tbl.size(); k++) begin
      cur = tbl[k].i;
      cycle();
      chk_vec($sformatf("vec%0d", k), dut_out(), tbl[k].e);
    end

    // Withdraw rejection, retry, and goMain winning over a same-cycle op_valid
    open_session(10);
    run(mk_in(0,1,1,0,0,0,1,40,0,0,10,0));
    chk("wd_reject_err", int'(op_err), 1);
    run(mk_in(0,1,1,0,0,0,1,5,0,0,10,0));
    chk("wd_retry_req", int'(dp_req), 1);
    chk("wd_retry_amt", int'(dp_amount), 5);
    run(mk_in(0,1,1,0,0,0,0,0,0,0,5,1));
    chk("wd_retry_done", int'(op_done), 1);
    cb_level = 8'd5;
    run(mk_in(0,1,1,0,0,0,1,40,0,0,5,0));
    run(mk_in(0,1,1,0,0,0,1,5,0,1,5,0));
    chk("gomain_no_req", int'(dp_req), 0);
    chk("gomain_active", int'(session_active), 1);
    run(idle_in());
    chk("gomain_still_idle", int'(dp_req), 0);

    // Deposit overflow boundary at the top of the balance range
    open_session(250);
    run(mk_in(0,1,1,0,0,1,1,0,10,0,250,0));
    chk("dep_ovf_err", int'(op_err), 1);
    chk("dep_ovf_noreq", int'(dp_req), 0);
    run(mk_in(0,1,1,0,0,1,1,0,5,0,250,0));
    chk("dep_op", int'(dp_op), 1);
    chk("dep_amt", int'(dp_amount), 5);
    run(idle_in());
    run(mk_in(0,1,1,0,0,0,0,0,0,0,255,1));
    chk("dep_done", int'(op_done), 1);
    chk("dep_shown", int'(shown_balance), 255);

    // Inactivity timeout from the menu
    open_session(40);
    for (int n = 1; n < TIMEOUT; n++) run(idle_in());
    chk("timeout_before", int'(card_eject), 0);
    run(idle_in());
    chk("timeout_eject", int'(card_eject), 1);
    run(idle_in());
    chk("timeout_after", int'(card_eject), 0);
    chk("timeout_inactive", int'(session_active), 0);

    // Card pulled during a balance read: handshake completes, then eject
    open_session(77);
    run(mk_in(0,1,1,0,0,2,1,0,0,0,77,0));
    run(mk_in(0,0,1,0,0,0,0,0,0,0,77,0));
    chk("pull_req_held", int'(dp_req), 1);
    run(mk_in(0,0,1,0,0,0,0,0,0,0,77,0));
    run(mk_in(0,0,1,0,0,0,0,0,0,0,77,1));
    chk("pull_done", int'(op_done), 1);
    chk("pull_eject", int'(card_eject), 1);
    chk("pull_shown", int'(shown_balance), 77);

    // Reset in the middle of a handshake
    open_session(60);
    run(mk_in(0,1,1,0,0,0,1,7,0,0,60,0));
    chk("rst_pre_req", int'(dp_req), 1);
    run(mk_in(1,1,1,0,0,0,0,0,0,0,60,1));
    chk_vec("rst_midreq", dut_out(), rs);

    // Random sessions against the model
    for (int n = 0; n < 3000; n++) begin
      in_t r;
      r.rst = ($urandom_range(0, 199) == 0);
      r.ic  = ($urandom_range(0, 39) != 0);
      r.lc  = $urandom_range(0, 1) != 0;
      r.pv  = ($urandom_range(0, 3) == 0);
      r.pin = ($urandom_range(0, 9) < 6) ? 4'(PIN_OK) : 4'($urandom_range(0, 15));
      r.ov  = ($urandom_range(0, 3) == 0);
      r.op  = 2'($urandom_range(0, 3));
      r.wd  = 6'($urandom_range(0, 63));
      r.dep = 5'($urandom_range(0, 31));
      r.gm  = ($urandom_range(0, 9) == 0);
      r.cb  = 8'($urandom_range(0, 255));
      r.ack = (m_ph == "EXEC") ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      cur = r;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
